mul_eis_ctl: RTL and testbench

//  Sequencer for the PDP-11 EIS MUL instruction. Accepts operands from the execute unit.

---
 rtl/mul_eis_ctl_if.sv | 12 +
 rtl/mul_eis_ctl.sv | 124 ++++++++++++
 tb/tb_mul_eis_ctl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_eis_ctl_if.sv
// Handshake bundle between the EIS MUL sequencer (master) and the shared 16x16 multiplier (slave).
interface mul_eis_ctl_if;
    logic        mul_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        mul_ovf;

    modport master (output mul_ready, mul_a, mul_b, input mul_done, mul_product, mul_ovf);
    modport slave  (input mul_ready, mul_a, mul_b, output mul_done, mul_product, mul_ovf);
endinterface

// File: rtl/mul_eis_ctl.sv
// PDP-11 EIS MUL sequencer: arms the shared multiplier, writes the product back to Rn/Rn|1
// and raises the MUL condition codes.
module mul_eis_ctl #(
    parameter int REG_AW  = 3,
    parameter bit ODD_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       src,
    input  logic [15:0]       dst_val,
    input  logic [REG_AW-1:0] dst_reg,
    output logic              busy,
    output logic              done,
    mul_eis_ctl_if.master     mul,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cc_we,
    output logic [3:0]        cc_nzvc
);

    typedef enum logic [2:0] {IDLE, REQ, WRHI, WRLO, FIN, DRAIN} state_t;

    state_t            state;
    logic [REG_AW-1:0] n_q;
    logic [31:0]       prod_q;
    logic              ovf_q;

    function automatic logic [3:0] cc_of(input logic [31:0] p, input logic ovf);
        return {p[31], (p == 32'd0), 1'b0, ovf};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mul.mul_ready <= 1'b0;
            mul.mul_a     <= '0;
            mul.mul_b     <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            cc_we         <= 1'b0;
            cc_nzvc       <= '0;
            n_q           <= '0;
            prod_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mul.mul_a     <= dst_val;
                        mul.mul_b     <= src;
                        n_q           <= dst_reg;
                        mul.mul_ready <= 1'b1;
                        busy          <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (abort) begin
                        mul.mul_ready <= 1'b0;
                        // Multiplier already finished this cycle: nothing left to drain.
                        if (mul.mul_done) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mul.mul_done) begin
                        mul.mul_ready <= 1'b0;
                        prod_q        <= mul.mul_product;
                        ovf_q         <= mul.mul_ovf;
                        wr_en         <= 1'b1;
                        wr_addr       <= n_q;
                        if (!n_q[0] || !ODD_LOW) begin
                            wr_data <= mul.mul_product[31:16];
                            state   <= WRHI;
                        end else begin
                            // Odd destination keeps only the low word; CCs go out with it.
                            wr_data <= mul.mul_product[15:0];
                            cc_we   <= 1'b1;
                            cc_nzvc <= cc_of(mul.mul_product, mul.mul_ovf);
                            state   <= WRLO;
                        end
                    end
                end
                WRHI: begin
                    wr_addr <= n_q | REG_AW'(1);
                    wr_data <= prod_q[15:0];
                    cc_we   <= 1'b1;
                    cc_nzvc <= cc_of(prod_q, ovf_q);
                    state   <= WRLO;
                end
                WRLO: begin
                    wr_en <= 1'b0;
                    cc_we <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mul.mul_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy          <= 1'b0;
                    mul.mul_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_eis_ctl.sv
// Directed bench for mul_eis_ctl with a behavioural multiplier of programmable latency.
module tb_mul_eis_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [15:0] src, dst_val;
    logic [2:0]  dst_reg;
    logic        busy, done, wr_en, cc_we;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  cc_nzvc;

    int total = 0;
    int bad   = 0;

    mul_eis_ctl_if mif();

    mul_eis_ctl #(.REG_AW(3), .ODD_LOW(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .src     (src),
        .dst_val (dst_val),
        .dst_reg (dst_reg),
        .busy    (busy),
        .done    (done),
        .mul     (mif),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cc_we   (cc_we),
        .cc_nzvc (cc_nzvc)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: arms on mul_ready, pulses mul_done mul_lat cycles later,
    // then waits for mul_ready to fall before it can be armed again.
    int          mul_lat = 1;
    int          mstate, mcnt;
    logic        mdone;
    logic [32:0] mres;

    function automatic logic [32:0] mulref(input logic [15:0] a, input logic [15:0] b);
        int sa, sb, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        return {(p > 32767 || p < -32768), p[31:0]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mstate <= 0;
            mcnt   <= 0;
            mdone  <= 1'b0;
            mres   <= '0;
        end else begin
            case (mstate)
                0: begin
                    mdone <= 1'b0;
                    if (mif.mul_ready) begin
                        mres <= mulref(mif.mul_a, mif.mul_b);
                        if (mul_lat <= 1) begin
                            mdone  <= 1'b1;
                            mstate <= 2;
                        end else begin
                            mcnt   <= mul_lat - 1;
                            mstate <= 1;
                        end
                    end
                end
                1: begin
                    if (mcnt == 1) begin
                        mdone  <= 1'b1;
                        mstate <= 2;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
                default: begin
                    mdone <= 1'b0;
                    if (!mif.mul_ready) mstate <= 0;
                end
            endcase
        end
    end

    assign mif.mul_done    = mdone;
    assign mif.mul_product = mres[31:0];
    assign mif.mul_ovf     = mres[32];

    // Event log sampled away from the active edge.
    int          cyc_n  = 0;
    int          cc_n   = 0;
    int          done_n = 0;
    logic [3:0]  cc_last = '0;
    logic [2:0]  wa_q[$];
    logic [15:0] wd_q[$];
    int          wc_q[$];

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc_n);
        end
        if (cc_we === 1'b1) begin
            cc_n    = cc_n + 1;
            cc_last = cc_nzvc;
        end
        if (done === 1'b1) done_n = done_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_mul(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [2:0] n, input int lat, input bit ab, input int nw,
                           input logic [2:0] a0, input logic [15:0] d0,
                           input logic [2:0] a1, input logic [15:0] d1,
                           input logic [3:0] cc, input int elat);
        int  wb, cb, db, k;
        bit  seen;
        wb = wa_q.size();
        cb = cc_n;
        db = done_n;
        mul_lat = lat;
        src = s; dst_val = d; dst_reg = n;
        start = 1'b1; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 80) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, ".lat"}, k, elat);
        @(posedge clk); #1;
        chk({tag, ".idle"}, busy, 0);
        @(negedge clk); #1;
        chk({tag, ".nwr"}, wa_q.size() - wb, nw);
        if (wa_q.size() > wb) begin
            chk({tag, ".a0"}, wa_q[wb], a0);
            chk({tag, ".d0"}, wd_q[wb], d0);
        end
        if (nw == 2 && wa_q.size() > wb + 1) begin
            chk({tag, ".a1"}, wa_q[wb+1], a1);
            chk({tag, ".d1"}, wd_q[wb+1], d1);
            chk({tag, ".consec"}, wc_q[wb+1] - wc_q[wb], 1);
        end
        chk({tag, ".ccn"}, cc_n - cb, 1);
        chk({tag, ".cc"}, cc_last, cc);
        chk({tag, ".donen"}, done_n - db, 1);
    endtask

    initial begin
        int wb, cb, db;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        src = '0; dst_val = '0; dst_reg = '0;
        @(posedge clk); #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ready", mif.mul_ready, 0);
        chk("rst.wr_en", wr_en, 0);
        chk("rst.cc_we", cc_we, 0);
        chk("rst.wr_addr", wr_addr, 0);
        chk("rst.wr_data", wr_data, 0);
        chk("rst.cc", cc_nzvc, 0);
        chk("rst.a", mif.mul_a, 0);
        chk("rst.b", mif.mul_b, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_mul("pair5x3", 16'h0005, 16'h0003, 3'd2, 1, 1'b0, 2, 3'd2, 16'h0000, 3'd3, 16'h000F, 4'b0000, 4);
        run_mul("odd3xm2", 16'h0003, 16'hFFFE, 3'd1, 1, 1'b0, 1, 3'd1, 16'hFFFA, 3'd0, 16'h0000, 4'b1000, 3);
        // abort raised together with start must not cancel the new MUL
        run_mul("ovf", 16'h0002, 16'h7FFF, 3'd0, 2, 1'b1, 2, 3'd0, 16'h0000, 3'd1, 16'hFFFE, 4'b0001, 5);
        run_mul("zero", 16'hFFFB, 16'h0000, 3'd4, 4, 1'b0, 2, 3'd4, 16'h0000, 3'd5, 16'h0000, 4'b0100, 7);

        // abort five cycles into REQ
        wb = wa_q.size(); cb = cc_n; db = done_n;
        mul_lat = 10;
        src = 16'h0007; dst_val = 16'h0002; dst_reg = 3'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ab.ready", mif.mul_ready, 1);
        chk("ab.a", mif.mul_a, 16'h0002);
        chk("ab.b", mif.mul_b, 16'h0007);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab.ready_drop", mif.mul_ready, 0);
        chk("ab.busy_drain", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("ab.busy_at_done", busy, 1);
        @(posedge clk); #1;
        chk("ab.busy_after", busy, 0);
        chk("ab.ready_after", mif.mul_ready, 0);
        @(negedge clk); #1;
        chk("ab.nwr", wa_q.size() - wb, 0);
        chk("ab.ncc", cc_n - cb, 0);
        chk("ab.ndone", done_n - db, 0);
        run_mul("post_ab", 16'h0005, 16'h0003, 3'd2, 3, 1'b0, 2, 3'd2, 16'h0000, 3'd3, 16'h000F, 4'b0000, 6);

        // start while busy, then reset in the middle of REQ
        wb = wa_q.size(); db = done_n;
        mul_lat = 20;
        src = 16'h0005; dst_val = 16'h0003; dst_reg = 3'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        src = 16'h0009; dst_val = 16'h0009; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy2.b", mif.mul_b, 16'h0005);
        chk("busy2.a", mif.mul_a, 16'h0003);
        chk("busy2.busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mrst.busy", busy, 0);
        chk("mrst.ready", mif.mul_ready, 0);
        chk("mrst.wr_en", wr_en, 0);
        @(negedge clk); #1;
        chk("mrst.nwr", wa_q.size() - wb, 0);
        chk("mrst.ndone", done_n - db, 0);
        @(posedge clk); #1;
        run_mul("post_rst", 16'h0003, 16'h0004, 3'd2, 2, 1'b0, 2, 3'd2, 16'h0000, 3'd3, 16'h000C, 4'b0000, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
